// File: rtl/mask_pkg.sv
// Shared types and constants for the 2-share Boolean masking blocks.
package mask_pkg;

    localparam int SHARES     = 2;
    localparam int MASK_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RND = 2'd1,
        OUT      = 2'd2,
        REFRESH  = 2'd3
    } state_e;

endpackage

// File: rtl/mask_share_reg.sv
// Share-pair register: load (d ^ r, r) or XOR-refresh both shares with r.
// Every share bit comes straight from a flop.
module mask_share_reg
    import mask_pkg::*;
#(
    parameter int WIDTH = MASK_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_refresh,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_rnd,
    output logic [WIDTH-1:0] o_share0,
    output logic [WIDTH-1:0] o_share1
);

    logic [WIDTH-1:0] r_share0;
    logic [WIDTH-1:0] r_share1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_share0 <= '0;
            r_share1 <= '0;
        end else if (i_load) begin
            r_share0 <= i_data ^ i_rnd;
            r_share1 <= i_rnd;
        end else if (i_refresh) begin
            r_share0 <= r_share0 ^ i_rnd;
            r_share1 <= r_share1 ^ i_rnd;
        end
    end

    assign o_share0 = r_share0;
    assign o_share1 = r_share1;

endmodule

// File: rtl/mask_share_encoder.sv
// Masking encoder: word + fresh rnd -> registered 2-share pair.
// Define MASK_SHARE_REFRESH_EN to add a REFRESH step using a second rnd word.
module mask_share_encoder
    import mask_pkg::*;
#(
    parameter int WIDTH = MASK_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [WIDTH-1:0] rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_share0,
    output logic [WIDTH-1:0] o_share1,
    output logic [CNT_W-1:0] o_count
);

    state_e           r_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             w_load;
    logic             w_refresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_state <= WAIT_RND;
                    end
                end
                WAIT_RND: begin
                    if (rnd_valid) begin
                        // plain value must not outlive the masking step
                        r_data  <= '0;
`ifdef MASK_SHARE_REFRESH_EN
                        r_state <= REFRESH;
`else
                        r_state <= OUT;
`endif
                    end
                end
                REFRESH: begin
                    if (rnd_valid) begin
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_count <= r_count + 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign rnd_ready = (r_state == WAIT_RND) | (r_state == REFRESH);
    assign out_valid = (r_state == OUT);
    assign o_count   = r_count;

    assign w_load    = (r_state == WAIT_RND) & rnd_valid;
    assign w_refresh = (r_state == REFRESH) & rnd_valid;

    mask_share_reg #(
        .WIDTH(WIDTH)
    ) u_share_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_refresh(w_refresh),
        .i_data   (r_data),
        .i_rnd    (rnd),
        .o_share0 (o_share0),
        .o_share1 (o_share1)
    );

endmodule

// File: tb/tb_mask_share_encoder.sv
// Bench for mask_share_encoder: transaction-count reference model,
// per-cycle compare at negedge, directed literal checks, random traffic.
module tb_mask_share_encoder;

    localparam int W  = 2;
    localparam int CW = 8;
`ifdef MASK_SHARE_REFRESH_EN
    localparam int RPW = 2;
`else
    localparam int RPW = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          rnd_valid = 1'b0;
    logic          rnd_ready;
    logic [W-1:0]  rnd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  o_share0;
    logic [W-1:0]  o_share1;
    logic [CW-1:0] o_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mask_share_encoder #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready),
        .rnd      (rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o_share0 (o_share0),
        .o_share1 (o_share1),
        .o_count  (o_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: words accepted, delivered, rnd words consumed.
    int           m_acc, m_del, m_rc;
    logic [W-1:0] m_pend, m_mask, m_s0, m_s1;

    function automatic bit f_in_rdy();
        return m_acc == m_del;
    endfunction

    function automatic bit f_rnd_rdy();
        return (m_acc > m_del) && (m_rc < m_acc * RPW);
    endfunction

    function automatic bit f_out_vld();
        return (m_acc > m_del) && (m_rc == m_acc * RPW);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit ih, rh, oh;
        if (rst) begin
            m_acc = 0; m_del = 0; m_rc = 0;
            m_pend = '0; m_mask = '0;
            m_s0 = '0; m_s1 = '0;
        end else begin
            ih = in_valid && f_in_rdy();
            rh = rnd_valid && f_rnd_rdy();
            oh = out_ready && f_out_vld();
            if (ih) begin
                m_pend = in_data;
                m_mask = '0;
                m_acc++;
            end
            if (rh) begin
                m_mask ^= rnd;
                m_rc++;
                if (m_rc == m_acc * RPW) begin
                    m_s0 = m_pend ^ m_mask;
                    m_s1 = m_mask;
                end
            end
            if (oh) m_del++;
        end
    end

    bit wrap_on = 0;
    bit seen_ff = 0;
    bit seen_00 = 0;

    always @(negedge clk) begin
        chk("in_ready", in_ready, f_in_rdy());
        chk("rnd_ready", rnd_ready, f_rnd_rdy());
        chk("out_valid", out_valid, f_out_vld());
        chk("share0", o_share0, m_s0);
        chk("share1", o_share1, m_s1);
        chk("count", o_count, m_del % (1 << CW));
        if (out_valid)
            chk("unmask", o_share0 ^ o_share1, m_pend);
        if (wrap_on && m_del == 255 && !seen_ff) begin
            seen_ff = 1;
            chk("count_ff", o_count, 8'hFF);
        end
        if (wrap_on && m_del == 256 && !seen_00) begin
            seen_00 = 1;
            chk("count_wrap", o_count, 8'h00);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] s0_hold, s1_hold, dat;

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rnd_ready", rnd_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_share0", o_share0, 0);
        chk("rst_share1", o_share1, 0);
        chk("rst_count", o_count, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // basic encode with hand-computed shares
`ifdef MASK_SHARE_REFRESH_EN
        dat = 2'b01;
`else
        dat = 2'b11;
`endif
        in_valid = 1; in_data = dat; out_ready = 1;
        tick();
        in_valid = 0; rnd_valid = 1;
`ifdef MASK_SHARE_REFRESH_EN
        rnd = 2'b11;
`else
        rnd = 2'b01;
`endif
        chk("d_rnd_ready", rnd_ready, 1);
        chk("d_out_n1", out_valid, 0);
        tick();
`ifdef MASK_SHARE_REFRESH_EN
        rnd = 2'b10;
        chk("d_rnd_ready2", rnd_ready, 1);
        chk("d_out_n2", out_valid, 0);
        tick();
        chk("d_share0", o_share0, 2'b00);
        chk("d_share1", o_share1, 2'b01);
`else
        chk("d_share0", o_share0, 2'b10);
        chk("d_share1", o_share1, 2'b01);
`endif
        chk("d_out_valid", out_valid, 1);
        chk("d_in_ready", in_ready, 0);
        rnd_valid = 0;
        tick();
        chk("d_count", o_count, 1);
        chk("d_out_done", out_valid, 0);

        // rnd starved for 5 cycles, then output stalled 4 cycles
        in_valid = 1; in_data = 2'b10; out_ready = 0;
        tick();
        in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stv_rnd_ready", rnd_ready, 1);
            chk("stv_out_valid", out_valid, 0);
            tick();
        end
        rnd_valid = 1; rnd = 2'b11;
        tick();
`ifdef MASK_SHARE_REFRESH_EN
        rnd = 2'b01;
        tick();
`endif
        rnd_valid = 0;
        chk("stv_out_late", out_valid, 1);
        s0_hold = o_share0;
        s1_hold = o_share1;
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("hold_in_ready", in_ready, 0);
            chk("hold_share0", o_share0, s0_hold);
            chk("hold_share1", o_share1, s1_hold);
            chk("hold_count", o_count, 1);
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick();
        chk("hold_count2", o_count, 2);
        chk("hold_in_ready2", in_ready, 1);

        // asynchronous reset while shares 10/01 are pending in OUT
        in_valid = 1; in_data = 2'b11; out_ready = 0;
        tick();
        in_valid = 0; rnd_valid = 1; rnd = 2'b01;
        tick();
`ifdef MASK_SHARE_REFRESH_EN
        rnd = 2'b00;
        tick();
`endif
        rnd_valid = 0;
        chk("pend_share0", o_share0, 2'b10);
        chk("pend_share1", o_share1, 2'b01);
        tick();
        #3 rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_share0", o_share0, 0);
        chk("ar_share1", o_share1, 0);
        chk("ar_count", o_count, 0);
        tick(); tick();
        rst = 1'b0;
        wrap_on = 1;

        // random traffic; long enough to wrap the counter
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            rnd_valid = ($urandom_range(0, 3) != 0);
            rnd       = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 0; rnd_valid = 0; out_ready = 0;
        tick();
        chk("seen_count_ff", seen_ff, 1);
        chk("seen_count_wrap", seen_00, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
